// File: rtl/bus_select_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_select_if: request/grant bundle between bus sources and encoder  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface bus_select_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  enc_out;
  logic        valid;
  logic [15:0] grant;
  logic        multi_err;
  logic        timeout;

  modport master (
    output req, done,
    input  enc_out, valid, grant, multi_err, timeout
  );

  modport slave (
    input  req, done,
    output enc_out, valid, grant, multi_err, timeout
  );
endinterface
`default_nettype wire

// File: rtl/bus_select_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_select_encoder: registered 16-to-4 bus-drive arbiter/encoder.    |
// | Optional BUS_SELECT_ROUND_ROBIN_EN selects round-robin arbitration.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bus_select_encoder #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  wire          clock,
  input  wire          clear,
  bus_select_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       enc_reg;
  logic             valid_reg;
  logic [15:0]      grant_reg;
  logic             multi_reg;
  logic             timeout_reg;

  logic [3:0]       search_base;
  logic [3:0]       sel_idx;
  logic [3:0]       cand;
  logic             found;
  logic             multi_req;
  logic             hold_hit;
  logic             owner_req;
  logic             release_now;

`ifdef BUS_SELECT_ROUND_ROBIN_EN
  logic [3:0] ptr;

  // Search starts just past the last winner so every requester gets a turn.
  assign search_base = ptr + 4'd1;

  always_ff @(posedge clock) begin
    if (!clear) begin
      ptr <= 4'hF;
    end else if (state == ST_IDLE && bus.req != 16'h0000) begin
      ptr <= sel_idx;
    end
  end
`else
  assign search_base = 4'd0;
`endif

  always_comb begin
    sel_idx = 4'd0;
    cand    = 4'd0;
    found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cand = search_base + 4'(i);
      if (!found && bus.req[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign multi_req = (bus.req & (bus.req - 16'd1)) != 16'h0000;
  assign owner_req = bus.req[enc_reg];

  generate
    if (MAX_HOLD != 0) begin : g_hold_limit
      assign hold_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    end else begin : g_hold_unlimited
      assign hold_hit = 1'b0;
    end
  endgenerate

  assign release_now = bus.done || !owner_req || hold_hit;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      enc_reg     <= 4'd0;
      valid_reg   <= 1'b0;
      grant_reg   <= 16'h0000;
      multi_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      multi_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.req != 16'h0000) begin
          state     <= ST_GRANT;
          enc_reg   <= sel_idx;
          grant_reg <= 16'h0001 << sel_idx;
          valid_reg <= 1'b1;
          hold_cnt  <= '0;
          multi_reg <= multi_req;
        end
      end else begin
        if (release_now) begin
          // enc_out deliberately keeps the last owner after release.
          state       <= ST_IDLE;
          valid_reg   <= 1'b0;
          grant_reg   <= 16'h0000;
          hold_cnt    <= '0;
          timeout_reg <= hold_hit && !bus.done && owner_req;
        end else begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.enc_out   = enc_reg;
  assign bus.valid     = valid_reg;
  assign bus.grant     = grant_reg;
  assign bus.multi_err = multi_reg;
  assign bus.timeout   = timeout_reg;

endmodule
`default_nettype wire

// File: doc/bus_select_encoder.md
Name: bus_select_encoder

Overview:
- Registered 16-to-4 encoder/arbiter, the inverse of the 4-to-16 register-select decoder.
- Collects the 16 per-source bus drive requests and produces a 4-bit encoded select for the bus mux, plus a one-hot grant back to the sources.
- Holds each grant until the source releases it or a hold timeout expires.
- Sits between the control unit's per-register "out" strobes and the shared bus multiplexer.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held before a forced release; 0 disables the timeout.
- CNT_W, 5: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock, in, 1: system clock; all state updates on the rising edge.
- clear, in, 1: synchronous active-low reset, sampled on the rising edge of clock.
- req, in, 16: request lines; bit i = source i wants the bus.
- done, in, 1: the granted source releases the bus.
- enc_out, out, 4: encoded index of the granted source.
- valid, out, 1: enc_out/grant are meaningful.
- grant, out, 16: one-hot grant, bit enc_out set while valid=1, all zero otherwise.
- multi_err, out, 1: one-cycle pulse, more than one req bit was set at arbitration.
- timeout, out, 1: one-cycle pulse, grant was force-released by MAX_HOLD.

Behaviour:
- Reset, when clear=0 at a clock edge:
  - State goes to IDLE.
  - enc_out=0, valid=0, grant=0, multi_err=0, timeout=0.
  - Hold counter=0; round-robin pointer=15.
  - Reset mid-grant drops valid/grant on that edge; there is no completion cycle.
- All outputs are registered; none is combinational from inputs.
- IDLE state:
  - If req != 0 at an edge, select index i, then set enc_out=i, grant=1<<i, valid=1, counter=0, and go to GRANT.
  - Latency is 1 cycle from req sampled to valid high.
  - multi_err=1 for that same cycle if popcount(req) > 1; otherwise 0.
  - If req == 0, stay in IDLE with valid=0.
- Selection (default): fixed priority, lowest set index wins.
- GRANT state:
  - enc_out and grant are held stable and valid=1.
  - Counter increments each cycle.
  - Release condition is any of: done=1, req[enc_out]=0, or (MAX_HOLD != 0 and counter == MAX_HOLD-1).
  - On release: next cycle valid=0, grant=0, state IDLE; enc_out keeps its last value.
- Turnaround: at least one IDLE cycle (valid=0) between consecutive grants, so the bus never switches drivers without a gap.
- timeout pulses for 1 cycle, coincident with valid falling, only when the release was caused by MAX_HOLD and neither done nor req-drop was present. When done and the timeout coincide, done wins and timeout=0.
- Changes to other req bits during GRANT are ignored; they are arbitrated on the next IDLE edge.
- multi_err and timeout are 0 in every cycle other than their pulse.

Optional Feature:
- Macro: BUS_SELECT_ROUND_ROBIN_EN.
- Defined:
  - Selection searches from (ptr+1) mod 16 upward, wrapping 15->0; the first set bit wins.
  - ptr is loaded with the granted index on every grant.
  - With ptr reset to 15, the first grant after reset matches fixed priority.
- Undefined: fixed lowest-index priority; no ptr register is synthesised.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/single request: clear=0 for 2 cycles, then req=0x0020 → next cycle enc_out=5, grant=0x0020, valid=1, multi_err=0. done=1 for one cycle → next cycle valid=0, grant=0.
- Fixed priority, macro undefined: req=0x8104 held, done pulsed after each grant → grants 2, 2, 2 with an IDLE gap between each, multi_err=1 on each grant cycle.
- Round-robin, macro defined: req=0x8104 held, done pulsed each grant → grant order 2, 8, 15, 2, each grant separated by one valid=0 cycle.
- Timeout: MAX_HOLD=4, req=0x0001 held, done=0 → valid high for exactly 4 cycles, timeout=1 on the cycle valid drops, re-grant of 0 after one IDLE cycle.
- Request drop and simultaneous events: grant 3, then req[3]→0 with req[9]=1 → valid=0 for one cycle, then enc_out=9. done and timeout on the same edge → timeout stays 0.
- Reset mid-grant: while granting 7, clear=0 for one edge → that edge gives valid=0, grant=0, enc_out=0. After clear=1 with req=0x0080 held → re-grant of 7 one cycle later.
